seq_code_lock: RTL and testbench

- Successor to the single-cycle switch-vs-digit comparator.
- Checks a parametrised N-digit code entered one digit at a time: digit on switches, one press of the enter key per digit.
- Adds retry counting, a timed lockout, and a clear function.
- Sits between the synchronised KEY/SW inputs and the LEDR/HEX drivers of the board top level.

---
 rtl/seq_code_lock_pkg.sv | 15 +
 rtl/rise_edge_det.sv | 26 ++
 rtl/seq_code_lock.sv | 166 ++++++++++++++++
 tb/tb_seq_code_lock.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_code_lock_pkg.sv
// Shared types for the sequential code lock.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seq_code_lock_pkg;

    typedef enum logic [1:0] {
        ENTRY,
        FAIL,
        UNLOCKED,
        LOCKOUT
    } lock_state_t;

    localparam int TRIES_W = 4;

endpackage

// File: rtl/rise_edge_det.sv
// Rising-edge detector: one-cycle pulse on each low-to-high transition of in.
// Latency: pulse is combinational on the cycle in first goes high.
// Backpressure: none; history resets to 1 so a level held through reset is not an edge.
module rise_edge_det (
    input  logic clk,
    input  logic reset_n,
    input  logic in,
    output logic pulse
);

    logic in_q;
    logic in_d;

    assign in_d  = in;
    assign pulse = in & ~in_q;

    // Remember the previous level of the input every cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_q <= 1'b1;
        end else begin
            in_q <= in_d;
        end
    end

endmodule

// File: rtl/seq_code_lock.sv
// Sequential N-digit code lock with retry counting, timed lockout and clear.
// Latency: every output is registered and updates on the edge that detects the press.
// Backpressure: none; presses are ignored while unlocked or locked out, clear beats a press.
module seq_code_lock
    import seq_code_lock_pkg::*;
#(
    parameter int                          DIGIT_W     = 4,
    parameter int                          N_DIGITS    = 4,
    parameter logic [N_DIGITS*DIGIT_W-1:0] CODE        = 16'h1234,
    parameter int                          MAX_TRIES   = 3,
    parameter int                          LOCK_CYCLES = 50_000_000
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [DIGIT_W-1:0]                digit_in,
    input  logic                              enter,
    input  logic                              clear,
    output logic                              unlocked,
    output logic                              fail,
    output logic                              locked_out,
    output logic [$clog2(N_DIGITS+1)-1:0]     digits_entered,
    output logic [TRIES_W-1:0]                tries_left
);

    localparam int DE_W  = $clog2(N_DIGITS + 1);
    localparam int CNT_W = $clog2(LOCK_CYCLES + 1);

    localparam logic [TRIES_W-1:0] TRIES_MAX  = TRIES_W'(MAX_TRIES);
    localparam logic [TRIES_W-1:0] TRIES_ONE  = TRIES_W'(1);
    localparam logic [DE_W-1:0]    LAST_IDX   = DE_W'(N_DIGITS - 1);
    localparam logic [CNT_W-1:0]   LOCK_LAST  = CNT_W'(LOCK_CYCLES - 1);

    lock_state_t         state_q,    state_d;
    logic [DE_W-1:0]     digits_q,   digits_d;
    logic [TRIES_W-1:0]  tries_q,    tries_d;
    logic                mism_q,     mism_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic                unlocked_q, unlocked_d;
    logic                fail_q,     fail_d;
    logic                locked_q,   locked_d;

    logic                press;
    logic [DIGIT_W-1:0]  exp_digit;
    logic                digit_bad;
    logic                last_digit;

    rise_edge_det u_enter_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .in      (enter),
        .pulse   (press)
    );

    // Select the code digit expected at the current position, MS digit first.
    always_comb begin
        exp_digit = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (digits_q == DE_W'(i)) begin
                exp_digit = CODE[(N_DIGITS-1-i)*DIGIT_W +: DIGIT_W];
            end
        end
    end

    assign digit_bad  = (digit_in != exp_digit);
    assign last_digit = (digits_q == LAST_IDX);

    // Next-state logic: digit entry, attempt evaluation, clear and lockout timing.
    always_comb begin
        state_d    = state_q;
        digits_d   = digits_q;
        tries_d    = tries_q;
        mism_d     = mism_q;
        cnt_d      = cnt_q;
        unlocked_d = unlocked_q;
        fail_d     = fail_q;
        locked_d   = locked_q;

        case (state_q)
            ENTRY, FAIL: begin
                if (clear) begin
                    // Abandon the partial entry without refunding any tries.
                    state_d  = ENTRY;
                    digits_d = '0;
                    mism_d   = 1'b0;
                    fail_d   = 1'b0;
                end else if (press) begin
                    // A press in FAIL starts a fresh attempt at digit 0.
                    state_d = ENTRY;
                    fail_d  = 1'b0;
                    if (last_digit) begin
                        digits_d = '0;
                        mism_d   = 1'b0;
                        if (!(mism_q || digit_bad)) begin
                            state_d    = UNLOCKED;
                            unlocked_d = 1'b1;
                            tries_d    = TRIES_MAX;
                        end else if (tries_q == TRIES_ONE) begin
                            state_d  = LOCKOUT;
                            locked_d = 1'b1;
                            tries_d  = '0;
                            cnt_d    = '0;
                        end else begin
                            state_d = FAIL;
                            fail_d  = 1'b1;
                            tries_d = tries_q - TRIES_ONE;
                        end
                    end else begin
                        digits_d = digits_q + DE_W'(1);
                        mism_d   = mism_q | digit_bad;
                    end
                end
            end
            UNLOCKED: begin
                if (clear) begin
                    state_d    = ENTRY;
                    unlocked_d = 1'b0;
                    digits_d   = '0;
                    tries_d    = TRIES_MAX;
                end
            end
            LOCKOUT: begin
                if (cnt_q == LOCK_LAST) begin
                    state_d  = ENTRY;
                    locked_d = 1'b0;
                    tries_d  = TRIES_MAX;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ENTRY;
            end
        endcase
    end

    // Register FSM state, counters and all outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ENTRY;
            digits_q   <= '0;
            tries_q    <= TRIES_MAX;
            mism_q     <= 1'b0;
            cnt_q      <= '0;
            unlocked_q <= 1'b0;
            fail_q     <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            digits_q   <= digits_d;
            tries_q    <= tries_d;
            mism_q     <= mism_d;
            cnt_q      <= cnt_d;
            unlocked_q <= unlocked_d;
            fail_q     <= fail_d;
            locked_q   <= locked_d;
        end
    end

    assign unlocked       = unlocked_q;
    assign fail           = fail_q;
    assign locked_out     = locked_q;
    assign digits_entered = digits_q;
    assign tries_left     = tries_q;

endmodule

// File: tb/tb_seq_code_lock.sv
// Testbench for seq_code_lock: directed steps plus random stimulus against a reference model.
// Latency: outputs compared 1 ns after every rising clk edge.
// Backpressure: n/a.
module tb_seq_code_lock;

    localparam int          N    = 4;
    localparam int          W    = 4;
    localparam int          CODE = 'h1234;
    localparam int          MAXT = 3;
    localparam int          LC   = 8;

    logic         clk;
    logic         reset_n;
    logic [W-1:0] digit_in;
    logic         enter;
    logic         clear;
    logic         unlocked;
    logic         fail;
    logic         locked_out;
    logic [2:0]   digits_entered;
    logic [3:0]   tries_left;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: entered digits kept as a list, the attempt is judged as a whole.
    int m_digits[$];
    int m_tries;
    int m_lock_left;
    bit m_unl;
    bit m_fail;
    bit m_prev_enter;

    seq_code_lock #(
        .DIGIT_W     (W),
        .N_DIGITS    (N),
        .CODE        (16'h1234),
        .MAX_TRIES   (MAXT),
        .LOCK_CYCLES (LC)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .digit_in       (digit_in),
        .enter          (enter),
        .clear          (clear),
        .unlocked       (unlocked),
        .fail           (fail),
        .locked_out     (locked_out),
        .digits_entered (digits_entered),
        .tries_left     (tries_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int code_digit(input int pos);
        int p;
        p = 1;
        for (int k = 0; k < N - 1 - pos; k++) p = p * 16;
        return (CODE / p) % 16;
    endfunction

    task automatic model_reset();
        m_digits.delete();
        m_tries      = MAXT;
        m_lock_left  = 0;
        m_unl        = 1'b0;
        m_fail       = 1'b0;
        m_prev_enter = 1'b1;
    endtask

    task automatic model_step();
        bit press;
        int val;
        press        = enter && !m_prev_enter;
        m_prev_enter = enter;
        if (m_lock_left > 0) begin
            m_lock_left--;
            if (m_lock_left == 0) m_tries = MAXT;
        end else if (m_unl) begin
            if (clear) begin
                m_unl   = 1'b0;
                m_tries = MAXT;
                m_digits.delete();
            end
        end else if (clear) begin
            m_digits.delete();
            m_fail = 1'b0;
        end else if (press) begin
            m_fail = 1'b0;
            m_digits.push_back(int'(digit_in));
            if (m_digits.size() == N) begin
                val = 0;
                foreach (m_digits[k]) val = val * 16 + m_digits[k];
                if (val == CODE) begin
                    m_unl   = 1'b1;
                    m_tries = MAXT;
                end else if (m_tries == 1) begin
                    m_lock_left = LC;
                    m_tries     = 0;
                end else begin
                    m_fail  = 1'b1;
                    m_tries = m_tries - 1;
                end
                m_digits.delete();
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".unlocked"}, 32'(unlocked),       32'(m_unl));
        chk({tag, ".fail"},     32'(fail),           32'(m_fail));
        chk({tag, ".locked"},   32'(locked_out),     32'(m_lock_left > 0));
        chk({tag, ".digits"},   32'(digits_entered), 32'(m_digits.size()));
        chk({tag, ".tries"},    32'(tries_left),     32'(m_tries));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        model_step();
        compare_all(tag);
    endtask

    task automatic press(input int d);
        digit_in = W'(d);
        enter    = 1'b1;
        tick("press");
        enter    = 1'b0;
        tick("release");
    endtask

    // Asserts reset between edges and checks the reset values before any clock edge.
    task automatic do_reset(input string tag);
        #1;
        reset_n = 1'b0;
        #1;
        chk({tag, ".unlocked"}, 32'(unlocked),       32'd0);
        chk({tag, ".fail"},     32'(fail),           32'd0);
        chk({tag, ".locked"},   32'(locked_out),     32'd0);
        chk({tag, ".digits"},   32'(digits_entered), 32'd0);
        chk({tag, ".tries"},    32'(tries_left),     32'(MAXT));
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b1;
    endtask

    task automatic wrong_attempt();
        press(1); press(2); press(3); press(5);
    endtask

    initial begin
        int cnt;
        reset_n  = 1'b1;
        enter    = 1'b0;
        clear    = 1'b0;
        digit_in = '0;
        model_reset();

        // Reset state
        do_reset("rst");
        tick("idle");

        // Correct code unlocks, extra press ignored, clear relocks
        press(1); press(2); press(3); press(4);
        chk("ok.unl",   32'(unlocked),   32'd1);
        chk("ok.tries", 32'(tries_left), 32'd3);
        press(9);
        chk("ok.ign_unl", 32'(unlocked),       32'd1);
        chk("ok.ign_dig", 32'(digits_entered), 32'd0);
        clear = 1'b1; tick("clr"); clear = 1'b0;
        chk("ok.clr_unl", 32'(unlocked),       32'd0);
        chk("ok.clr_dig", 32'(digits_entered), 32'd0);

        // One wrong digit
        wrong_attempt();
        chk("bad.fail",  32'(fail),       32'd1);
        chk("bad.tries", 32'(tries_left), 32'd2);
        chk("bad.unl",   32'(unlocked),   32'd0);
        press(1);
        chk("bad.fail_clr", 32'(fail),           32'd0);
        chk("bad.digits",   32'(digits_entered), 32'd1);
        clear = 1'b1; tick("clr"); clear = 1'b0;
        chk("bad.clr_tries", 32'(tries_left), 32'd2);

        // Lockout after three wrong attempts, exactly LC cycles
        do_reset("rst2");
        tick("idle");
        wrong_attempt();
        wrong_attempt();
        press(1); press(2); press(3);
        digit_in = 4'd5;
        enter    = 1'b1;
        tick("lk_enter");
        chk("lk.locked", 32'(locked_out), 32'd1);
        chk("lk.tries",  32'(tries_left), 32'd0);
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            enter    = ~enter;
            clear    = 1'b1;
            digit_in = 4'd1;
            tick("lk_hold");
            if (locked_out) cnt++;
            else break;
        end
        clear = 1'b0;
        enter = 1'b0;
        tick("lk_exit");
        chk("lk.cycles",     32'(cnt),        32'(LC));
        chk("lk.exit_lock",  32'(locked_out), 32'd0);
        chk("lk.exit_tries", 32'(tries_left), 32'd3);
        press(1); press(2); press(3); press(4);
        chk("lk.then_unl", 32'(unlocked), 32'd1);
        clear = 1'b1; tick("clr"); clear = 1'b0;

        // Clear rules
        press(1); press(2);
        clear = 1'b1; tick("clr"); clear = 1'b0;
        chk("clr.digits", 32'(digits_entered), 32'd0);
        chk("clr.tries",  32'(tries_left),     32'd3);
        digit_in = 4'd3;
        enter    = 1'b1;
        clear    = 1'b1;
        tick("clr_press");
        chk("clr.press_digits", 32'(digits_entered), 32'd0);
        enter = 1'b0;
        clear = 1'b0;
        tick("idle");

        // Enter held for 20 cycles counts once
        digit_in = 4'd1;
        enter    = 1'b1;
        repeat (20) tick("hold");
        enter = 1'b0;
        tick("hold_rel");
        chk("hold.digits", 32'(digits_entered), 32'd1);
        clear = 1'b1; tick("clr"); clear = 1'b0;

        // Enter held through reset release is not a press
        enter = 1'b1;
        do_reset("rst_hold");
        repeat (3) tick("rst_hold");
        chk("rsthold.digits", 32'(digits_entered), 32'd0);
        enter = 1'b0;
        tick("idle");

        // Reset asserted mid-lockout acts immediately
        press(0); press(0); press(0); press(0);
        press(0); press(0); press(0); press(0);
        press(0); press(0); press(0); press(0);
        repeat (3) tick("lk_mid");
        chk("mid.locked_before", 32'(locked_out), 32'd1);
        do_reset("rst_mid");
        tick("idle");

        // Random stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            enter = 1'($urandom_range(1));
            clear = ($urandom_range(15) == 0);
            if (m_digits.size() < N && $urandom_range(3) != 0)
                digit_in = W'(code_digit(m_digits.size()));
            else
                digit_in = W'($urandom_range(15));
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
